// File: rtl/corelet_ctrl.sv
// Tile sequencer for one corelet: kernel fill/load, settle, activation fill/execute,
// then OFIFO drain with one SFU accumulate strobe per popped psum vector.
module corelet_ctrl #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int KER_LEN  = 8,
    parameter int PIPE_DLY = 16,
    parameter int ADDR_W   = 11,
    parameter int LEN_W    = 8,
    parameter int TMO      = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  act_len,
    input  logic [ADDR_W-1:0] k_base,
    input  logic [ADDR_W-1:0] a_base,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              l0_wr,
    output logic              l0_rd,
    output logic [1:0]        inst,
    input  logic              ofifo_valid,
    output logic              ofifo_rd,
    output logic              accum,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W  = 16;
    localparam int TMO_W  = $clog2(TMO + 1);
    // Settle must cover the full diagonal skew of the array even if PIPE_DLY is set too low.
    localparam int SETTLE = (PIPE_DLY > row + col) ? PIPE_DLY : row + col;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] K_FILL = 3'd1;
    localparam logic [2:0] K_LOAD = 3'd2;
    localparam logic [2:0] K_WAIT = 3'd3;
    localparam logic [2:0] A_FILL = 3'd4;
    localparam logic [2:0] EXEC   = 3'd5;
    localparam logic [2:0] DRAIN  = 3'd6;
    localparam logic [2:0] DONE   = 3'd7;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  pops_q, pops_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [LEN_W-1:0]  act_len_q, act_len_d;
    logic [ADDR_W-1:0] k_base_q, k_base_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;
    logic              err_q, err_d;
    logic              l0_wr_q, l0_wr_d;
    logic              accum_q, accum_d;
    logic [CNT_W-1:0]  act_len_c;

    assign act_len_c = CNT_W'(act_len_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pops_d    = pops_q;
        tmo_d     = tmo_q;
        act_len_d = act_len_q;
        k_base_d  = k_base_q;
        a_base_d  = a_base_q;
        err_d     = err_q;
        sram_en   = 1'b0;
        sram_addr = '0;
        l0_rd     = 1'b0;
        inst      = 2'b00;
        ofifo_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    act_len_d = act_len;
                    k_base_d  = k_base;
                    a_base_d  = a_base;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    pops_d    = '0;
                    tmo_d     = '0;
                    // A zero-length tile passes through DRAIN, which exits at once with no pop.
                    state_d   = (act_len == '0) ? DRAIN : K_FILL;
                end
            end
            K_FILL: begin
                if (cnt_q < CNT_W'(KER_LEN)) begin
                    sram_en   = 1'b1;
                    sram_addr = k_base_q + cnt_q[ADDR_W-1:0];
                end
                if (cnt_q == CNT_W'(KER_LEN)) begin
                    cnt_d   = '0;
                    state_d = K_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            K_LOAD: begin
                l0_rd = 1'b1;
                inst  = 2'b01;
                if (cnt_q == CNT_W'(KER_LEN - 1)) begin
                    cnt_d   = '0;
                    state_d = K_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            K_WAIT: begin
                if (cnt_q == CNT_W'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = A_FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            A_FILL: begin
                if (cnt_q < act_len_c) begin
                    sram_en   = 1'b1;
                    sram_addr = a_base_q + cnt_q[ADDR_W-1:0];
                end
                if (cnt_q == act_len_c) begin
                    cnt_d   = '0;
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EXEC: begin
                l0_rd = 1'b1;
                inst  = 2'b10;
                if (cnt_q + 1'b1 == act_len_c) begin
                    cnt_d   = '0;
                    pops_d  = '0;
                    tmo_d   = '0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                ofifo_rd = ofifo_valid && (pops_q < act_len_q);
                if (ofifo_rd) begin
                    pops_d = pops_q + 1'b1;
                    tmo_d  = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (pops_d == act_len_q) begin
                    state_d = DONE;
                end else if (!ofifo_rd && tmo_q == TMO_W'(TMO - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        l0_wr_d = sram_en;
        accum_d = ofifo_rd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pops_q    <= '0;
            tmo_q     <= '0;
            act_len_q <= '0;
            k_base_q  <= '0;
            a_base_q  <= '0;
            err_q     <= 1'b0;
            l0_wr_q   <= 1'b0;
            accum_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pops_q    <= pops_d;
            tmo_q     <= tmo_d;
            act_len_q <= act_len_d;
            k_base_q  <= k_base_d;
            a_base_q  <= a_base_d;
            err_q     <= err_d;
            l0_wr_q   <= l0_wr_d;
            accum_q   <= accum_d;
        end
    end

    assign l0_wr = l0_wr_q;
    assign accum = accum_q;
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign err   = err_q;
endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: per-cycle stimulus and expected outputs are queued
// from a phase-level tile model, then replayed and compared cycle by cycle.
module tb_corelet_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  act_len;
    logic [10:0] k_base;
    logic [10:0] a_base;
    logic        ofifo_valid;
    logic        sram_en;
    logic [10:0] sram_addr;
    logic        l0_wr;
    logic        l0_rd;
    logic [1:0]  inst;
    logic        ofifo_rd;
    logic        accum;
    logic        busy;
    logic        done;
    logic        err;

    corelet_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .act_len(act_len),
        .k_base(k_base), .a_base(a_base), .sram_en(sram_en), .sram_addr(sram_addr),
        .l0_wr(l0_wr), .l0_rd(l0_rd), .inst(inst), .ofifo_valid(ofifo_valid),
        .ofifo_rd(ofifo_rd), .accum(accum), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit model_err = 1'b0;

    logic        st_q[$];
    logic [7:0]  len_q[$];
    logic [10:0] kb_q[$];
    logic [10:0] ab_q[$];
    logic        v_q[$];
    logic [20:0] exp_q[$];
    string       tag_q[$];

    // {busy, done, err, sram_en, sram_addr, l0_wr, l0_rd, inst, ofifo_rd, accum}
    function automatic logic [20:0] pk(input logic b, input logic d, input logic e,
                                       input logic en, input logic [10:0] ad,
                                       input logic wr, input logic rd, input logic [1:0] in,
                                       input logic ord, input logic acc);
        return {b, d, e, en, ad, wr, rd, in, ord, acc};
    endfunction

    function automatic logic [20:0] obs();
        return {busy, done, err, sram_en, sram_addr, l0_wr, l0_rd, inst, ofifo_rd, accum};
    endfunction

    task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic push(input logic st, input logic [7:0] len, input logic [10:0] kb,
                        input logic [10:0] ab, input logic v, input logic [20:0] e,
                        input string tag);
        st_q.push_back(st);
        len_q.push_back(len);
        kb_q.push_back(kb);
        ab_q.push_back(ab);
        v_q.push_back(v);
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++)
            push(1'b0, 8'd9, 11'h155, 11'h2AA, 1'b1, pk(0, 0, model_err, 0, 0, 0, 0, 2'b00, 0, 0), "idle");
    endtask

    // vmode: 0 = ofifo_valid tied 1, 1 = 1,0,0 pattern in DRAIN, 2 = held 0.
    // poke: extra start pulses and a changed act_len while the tile is busy.
    task automatic model_tile(input int al, input logic [10:0] kb, input logic [10:0] ab,
                              input int vmode, input bit poke);
        logic [7:0]  blen;
        logic        bv;
        logic [10:0] a;
        int          pops, idle, j;
        bit          rd, prd, v;
        blen = poke ? 8'd3 : al[7:0];
        bv   = (vmode != 2);
        push(1'b1, al[7:0], kb, ab, bv, pk(0, 0, model_err, 0, 0, 0, 0, 2'b00, 0, 0), "start");
        model_err = 1'b0;
        if (al == 0) begin
            push(1'b0, blen, ~kb, ~ab, bv, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "zl_pass");
            push(1'b0, blen, ~kb, ~ab, bv, pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0), "zl_done");
            return;
        end
        for (int i = 0; i <= 8; i++) begin
            a = (i < 8) ? kb + 11'(i) : 11'h000;
            push(poke && i == 3, blen, ~kb, ~ab, bv,
                 pk(1, 0, 0, i < 8, a, i > 0, 0, 2'b00, 0, 0), "k_fill");
        end
        for (int i = 0; i < 8; i++)
            push(1'b0, blen, ~kb, ~ab, bv, pk(1, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0), "k_load");
        for (int i = 0; i < 16; i++)
            push(1'b0, blen, ~kb, ~ab, bv, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0), "k_wait");
        for (int i = 0; i <= al; i++) begin
            a = (i < al) ? ab + 11'(i) : 11'h000;
            push(1'b0, blen, ~kb, ~ab, bv, pk(1, 0, 0, i < al, a, i > 0, 0, 2'b00, 0, 0), "a_fill");
        end
        for (int i = 0; i < al; i++)
            push(1'b0, blen, ~kb, ~ab, bv, pk(1, 0, 0, 0, 0, 0, 1, 2'b10, 0, 0), "exec");
        pops = 0; idle = 0; j = 0; prd = 1'b0;
        forever begin
            v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (j % 3 == 0) : 1'b0;
            rd = v && (pops < al);
            push(poke && j == 0, blen, ~kb, ~ab, v, pk(1, 0, 0, 0, 0, 0, 0, 2'b00, rd, prd), "drain");
            j++;
            if (rd) begin pops++; idle = 0; end
            else idle++;
            prd = rd;
            if (pops == al) begin
                push(1'b0, blen, ~kb, ~ab, bv, pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, prd), "done");
                break;
            end
            if (idle == 255) begin
                model_err = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_n(input int n);
        logic [20:0] e;
        string t;
        for (int i = 0; i < n && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            start       = st_q.pop_front();
            act_len     = len_q.pop_front();
            k_base      = kb_q.pop_front();
            a_base      = ab_q.pop_front();
            ofifo_valid = v_q.pop_front();
            @(negedge clk);
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, obs(), e);
        end
    endtask

    task automatic flush();
        st_q.delete(); len_q.delete(); kb_q.delete(); ab_q.delete();
        v_q.delete(); exp_q.delete(); tag_q.delete();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; act_len = '0; k_base = '0; a_base = '0; ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs(), 21'h0);
        reset = 1'b1;

        model_tile(4, 11'h000, 11'h040, 0, 1'b0);
        push_idle(2);
        run_n(100000);

        model_tile(0, 11'h010, 11'h020, 0, 1'b0);
        push_idle(2);
        run_n(100000);

        model_tile(5, 11'h7FC, 11'h7FE, 1, 1'b1);
        push_idle(2);
        run_n(100000);

        model_tile(3, 11'h100, 11'h200, 2, 1'b0);
        push_idle(3);
        run_n(100000);

        model_tile(2, 11'h008, 11'h030, 0, 1'b0);
        push_idle(2);
        run_n(100000);

        // Reset mid-EXEC: cycles 0..40 of a 4-vector tile end inside EXEC.
        model_tile(4, 11'h000, 11'h040, 0, 1'b0);
        run_n(41);
        flush();
        #2 reset = 1'b0;
        #1 check("reset_async", obs(), 21'h0);
        @(posedge clk);
        #1 check("reset_edge", obs(), 21'h0);
        reset = 1'b1;
        start = 1'b0;
        model_err = 1'b0;
        model_tile(4, 11'h000, 11'h040, 0, 1'b0);
        push_idle(2);
        run_n(100000);

        model_tile(255, 11'h000, 11'h400, 0, 1'b0);
        push_idle(2);
        run_n(100000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
